// File: rtl/rmt_alu_pkg.sv
// Shared opcode map and field widths for the RMT action-stage container ALU.
package rmt_alu_pkg;

  localparam int OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD     = 4'b0001;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB     = 4'b0010;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI    = 4'b0011;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI    = 4'b0100;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND     = 4'b0101;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR      = 4'b0110;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR     = 4'b0111;
  localparam logic [OPCODE_WIDTH-1:0] OP_SET     = 4'b1000;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD_ALT = 4'b1001;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB_ALT = 4'b1010;
  localparam logic [OPCODE_WIDTH-1:0] OP_SADD    = 4'b1011;
  localparam logic [OPCODE_WIDTH-1:0] OP_SSUB    = 4'b1100;

endpackage

// File: rtl/alu_delay_line.sv
// Valid-gated shift register: each stage loads its predecessor only when the
// predecessor is valid, so the tail holds the last valid payload between strobes.
module alu_delay_line #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH:0]   src_valid_s;
  logic [WIDTH-1:0] src_data_s [DEPTH+1];

  // Next-state of every stage; stage i is fed by stage i-1 (stage 0 by the input).
  always_comb begin
    src_valid_s   = {valid_q, in_valid};
    src_data_s[0] = in_data;
    for (int i = 1; i <= DEPTH; i++) begin
      src_data_s[i] = data_q[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = src_valid_s[i];
      if (src_valid_s[i]) begin
        data_d[i] = src_data_s[i];
      end else begin
        data_d[i] = data_q[i];
      end
    end
  end

  // Stage registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/alu_pipe.sv
// Fully pipelined container ALU for one PHV slot of an RMT action stage.
// One action per clock, fixed LATENCY, results in issue order, no back-pressure.
module alu_pipe
  import rmt_alu_pkg::*;
#(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int IMM_WIDTH  = 16,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid,
  input  logic [DATA_WIDTH-1:0] operand_1_in,
  input  logic [DATA_WIDTH-1:0] operand_2_in,
  output logic [DATA_WIDTH-1:0] container_out,
  output logic                  container_out_valid,
  output logic                  overflow_out
);

  logic [OPCODE_WIDTH-1:0] opcode_s;
  logic [DATA_WIDTH-1:0]   imm_ext_s;
  logic [DATA_WIDTH-1:0]   add_b_s;
  logic                    add_sub_s;
  logic [DATA_WIDTH:0]     sum_s;
  logic [DATA_WIDTH-1:0]   result_s;
  logic                    overflow_s;
  logic                    unused_s;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_ovf_q, s1_ovf_d;

  // Decode and execute; add and subtract share one DATA_WIDTH+1 adder whose
  // top bit is the carry (add) or the inverted borrow (subtract as a + ~b + 1).
  always_comb begin
    opcode_s  = action_in[ACTION_LEN-1 -: OPCODE_WIDTH];
    imm_ext_s = '0;
    imm_ext_s[IMM_WIDTH-1:0] = action_in[IMM_WIDTH-1:0];

    case (opcode_s)
      OP_SUB, OP_SUB_ALT, OP_SSUB: begin
        add_b_s   = operand_2_in;
        add_sub_s = 1'b1;
      end
      OP_ADDI: begin
        add_b_s   = imm_ext_s;
        add_sub_s = 1'b0;
      end
      OP_SUBI: begin
        add_b_s   = imm_ext_s;
        add_sub_s = 1'b1;
      end
      default: begin
        add_b_s   = operand_2_in;
        add_sub_s = 1'b0;
      end
    endcase

    sum_s = {1'b0, operand_1_in}
          + {1'b0, (add_sub_s ? ~add_b_s : add_b_s)}
          + {{DATA_WIDTH{1'b0}}, add_sub_s};

    case (opcode_s)
      OP_ADD, OP_ADD_ALT, OP_ADDI: begin
        result_s   = sum_s[DATA_WIDTH-1:0];
        overflow_s = sum_s[DATA_WIDTH];
      end
      OP_SUB, OP_SUB_ALT, OP_SUBI: begin
        result_s   = sum_s[DATA_WIDTH-1:0];
        overflow_s = ~sum_s[DATA_WIDTH];
      end
      OP_AND: begin
        result_s   = operand_1_in & operand_2_in;
        overflow_s = 1'b0;
      end
      OP_OR: begin
        result_s   = operand_1_in | operand_2_in;
        overflow_s = 1'b0;
      end
      OP_XOR: begin
        result_s   = operand_1_in ^ operand_2_in;
        overflow_s = 1'b0;
      end
      OP_SET: begin
        result_s   = imm_ext_s;
        overflow_s = 1'b0;
      end
      OP_SADD: begin
        overflow_s = sum_s[DATA_WIDTH];
        result_s   = sum_s[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum_s[DATA_WIDTH-1:0];
      end
      OP_SSUB: begin
        overflow_s = ~sum_s[DATA_WIDTH];
        result_s   = sum_s[DATA_WIDTH] ? sum_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
      end
      default: begin
        result_s   = operand_1_in;
        overflow_s = 1'b0;
      end
    endcase
  end

  // Middle action bits and the stage index carry no function here.
  always_comb begin
    unused_s = (^action_in) ^ (STAGE_ID != 32'sd0);
  end

  // Stage 1 loads a new result only on a valid action and otherwise holds.
  always_comb begin
    s1_valid_d = action_valid;
    if (action_valid) begin
      s1_data_d = result_s;
      s1_ovf_d  = overflow_s;
    end else begin
      s1_data_d = s1_data_q;
      s1_ovf_d  = s1_ovf_q;
    end
  end

  // Stage 1 registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_ovf_q   <= s1_ovf_d;
    end
  end

  if (LATENCY == 1) begin : g_bypass
    assign container_out       = s1_data_q;
    assign overflow_out        = s1_ovf_q;
    assign container_out_valid = s1_valid_q;
  end else begin : g_delay
    logic [DATA_WIDTH:0] dl_data_s;

    alu_delay_line #(
      .WIDTH(DATA_WIDTH + 1),
      .DEPTH(LATENCY - 1)
    ) u_delay (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (s1_valid_q),
      .in_data  ({s1_ovf_q, s1_data_q}),
      .out_valid(container_out_valid),
      .out_data (dl_data_s)
    );

    assign container_out = dl_data_s[DATA_WIDTH-1:0];
    assign overflow_out  = dl_data_s[DATA_WIDTH];
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases plus random traffic,
// checked against a plain-arithmetic reference model with timing and hold checks.
module tb_alu_pipe;

  localparam int AL = 25;
  localparam int DW = 48;
  localparam int IW = 16;
  localparam int L  = 3;

  logic          clk;
  logic          rst_n;
  logic [AL-1:0] action_in;
  logic          action_valid;
  logic [DW-1:0] operand_1_in;
  logic [DW-1:0] operand_2_in;
  logic [DW-1:0] container_out;
  logic          container_out_valid;
  logic          overflow_out;

  alu_pipe #(
    .STAGE_ID  (0),
    .ACTION_LEN(AL),
    .DATA_WIDTH(DW),
    .IMM_WIDTH (IW),
    .LATENCY   (L)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .action_in          (action_in),
    .action_valid       (action_valid),
    .operand_1_in       (operand_1_in),
    .operand_2_in       (operand_2_in),
    .container_out      (container_out),
    .container_out_valid(container_out_valid),
    .overflow_out       (overflow_out)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          ovf;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] last_data = '0;
  logic          last_ovf = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: unsigned arithmetic on 64-bit values, MAX = 2^48-1.
  function automatic void model(input logic [3:0] op, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic [IW-1:0] imm,
                                output logic [DW-1:0] r, output logic o);
    logic [63:0] av, bv, iv, maxv, s;
    av = 64'(a); bv = 64'(b); iv = 64'(imm);
    maxv = (64'd1 << DW) - 64'd1;
    o = 1'b0;
    case (op)
      4'd1, 4'd9: begin s = av + bv; o = (s > maxv); r = DW'(s); end
      4'd2, 4'd10: begin o = (av < bv); r = DW'(av - bv); end
      4'd3: begin s = av + iv; o = (s > maxv); r = DW'(s); end
      4'd4: begin o = (av < iv); r = DW'(av - iv); end
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: r = DW'(iv);
      4'd11: begin s = av + bv; o = (s > maxv); r = o ? DW'(maxv) : DW'(s); end
      4'd12: begin o = (av < bv); r = o ? '0 : DW'(av - bv); end
      default: r = a;
    endcase
  endfunction

  // One clock of stimulus; a valid action issued while rst_n is high is scored.
  task automatic drive(input bit v, input logic [3:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [IW-1:0] imm, input bit rst);
    exp_t e;
    logic [AL-IW-5:0] filler;
    filler       = (AL-IW-4)'($urandom);
    rst_n        = ~rst;
    action_valid = v;
    action_in    = {op, filler, imm};
    operand_1_in = a;
    operand_2_in = b;
    if (v && !rst) begin
      model(op, a, b, imm, e.data, e.ovf);
      e.due = cyc + L;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_op();
    case ($urandom_range(0, 4))
      0: rand_op = '0;
      1: rand_op = {DW{1'b1}};
      2: rand_op = DW'($urandom_range(0, 15));
      3: rand_op = {DW{1'b1}} - DW'($urandom_range(0, 15));
      default: rand_op = {16'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 4'($urandom), rand_op(), rand_op(), 16'($urandom), 1'b0);
    end
  endtask

  // Reset flushes the model: in-flight actions are dropped, outputs return to 0.
  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      sb_q.delete();
      last_data = '0;
      last_ovf  = 1'b0;
      mon_en    = 1'b1;
    end
  end

  // Monitor: strobes must match the queue head in value and cycle; idle cycles must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (container_out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL strobe: unexpected valid at cycle %0d data=%h", cyc, container_out);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (e.due != cyc || container_out !== e.data || overflow_out !== e.ovf) begin
            n_err++;
            $display("FAIL result: cycle %0d data=%h ovf=%b expected cycle %0d data=%h ovf=%b",
                     cyc, container_out, overflow_out, e.due, e.data, e.ovf);
          end
          last_data = e.data;
          last_ovf  = e.ovf;
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        n_err++;
        $display("FAIL missing: no strobe at cycle %0d valid=%b, expected data=%h due %0d",
                 cyc, container_out_valid, e.data, e.due);
      end else if (container_out_valid !== 1'b0 || container_out !== last_data ||
                   overflow_out !== last_ovf) begin
        n_err++;
        $display("FAIL hold: cycle %0d valid=%b data=%h ovf=%b expected valid=0 data=%h ovf=%b",
                 cyc, container_out_valid, container_out, overflow_out, last_data, last_ovf);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    action_valid = 1'b0;
    action_in = '0;
    operand_1_in = '0;
    operand_2_in = '0;
    drive(1'b1, 4'd1, 48'd1, 48'd1, 16'd0, 1'b1);
    drive(1'b0, 4'd0, '0, '0, 16'd0, 1'b1);
    idle(4);

    // Directed corner cases with gaps so the hold behaviour is exercised.
    drive(1'b1, 4'b0001, 48'd10, 48'd5, 16'd0, 1'b0);
    idle(5);
    drive(1'b1, 4'b0010, 48'd0, 48'd1, 16'd0, 1'b0);
    idle(2);
    drive(1'b1, 4'b1011, 48'hFFFF_FFFF_FFF0, 48'h20, 16'd0, 1'b0);
    idle(2);
    drive(1'b1, 4'b1100, 48'd3, 48'd7, 16'd0, 1'b0);
    idle(2);
    drive(1'b1, 4'b0011, 48'd100, 48'd0, 16'h0010, 1'b0);
    drive(1'b1, 4'b1000, 48'd0, 48'd0, 16'hBEEF, 1'b0);
    drive(1'b1, 4'b1111, 48'h1234, 48'd99, 16'hFFFF, 1'b0);
    drive(1'b1, 4'b0100, 48'd5, 48'd0, 16'hFFFF, 1'b0);
    idle(6);

    // Back-to-back stream.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'b0001, DW'(i), DW'(i), 16'd0, 1'b0);
    end
    idle(6);

    // Action in flight when reset hits, and a valid during reset: both dropped.
    drive(1'b1, 4'b0001, 48'd7, 48'd8, 16'd0, 1'b0);
    drive(1'b1, 4'b0110, 48'hF0, 48'h0F, 16'd0, 1'b1);
    idle(8);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom), rand_op(), rand_op(),
            16'($urandom), $urandom_range(0, 99) == 0);
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      idle(1);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
